four_bit_adder: RTL and testbench
=================================

Name: four_bit_adder

Overview:
- Registered 4-bit ripple-carry adder with carry-in and carry-out.
- Operands and carry-in arrive as individual scalar bits. The 5-bit result (sum nibble plus carry-out) is captured in output registers on each rising clock edge.
- Used as a small arithmetic leaf: a nibble adder stage in datapaths and teaching/regression designs.

Parameters:
- None. Width is fixed at 4 bits by the scalar port list.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous reset, active-low
- a3  input  1  operand A bit 3 (MSB)
- b3  input  1  operand B bit 3 (MSB)
- a2  input  1  operand A bit 2
- b2  input  1  operand B bit 2
- a1  input  1  operand A bit 1
- b1  input  1  operand B bit 1
- a0  input  1  operand A bit 0 (LSB)
- b0  input  1  operand B bit 0 (LSB)
- cin  input  1  carry-in to bit 0
- s1  output  1  registered sum bit 0 (LSB)
- s2  output  1  registered sum bit 1
- s3  output  1  registered sum bit 2
- s4  output  1  registered sum bit 3 (MSB)
- c4  output  1  registered carry-out of bit 3

Port order on the module: clk, rst_n, then a3, b3, a2, b2, a1, b1, a0, b0, cin, s1, s2, s3, s4, c4.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Define A = {a3,a2,a1,a0} and B = {b3,b2,b1,b0}.
- Combinational core: ripple chain of four full adders.
  - Stage i: sum_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = cin.
- Result {c4,s4,s3,s2,s1} equals A + B + cin, computed in 5 bits. No truncation; max value is 15+15+1 = 31 = 5'b11111.
- Register update on each rising edge of clk:
  - rst_n = 0: s1..s4 and c4 all load 0.
  - rst_n = 1: {c4,s4,s3,s2,s1} loads the core result.
- Latency: exactly one cycle. Inputs applied before edge N appear on the outputs after edge N. Outputs hold until the next edge.
- No enable or handshake. The register loads every cycle while out of reset.
- Reset has priority over operand inputs on the same edge.
- Reset mid-operation: the result in flight is discarded. Outputs read 0 from that edge until the first edge with rst_n = 1, which loads the then-current sum.
- Outputs after power-up and before the first reset edge are undefined. Benches must reset first.
- Unsigned arithmetic only. No overflow flag; c4 is the unsigned carry.
- Inputs are assumed stable around the clk edge (standard synchronous timing). No X-handling logic is required.

Decomposition:
- Shared package: constant ADDER_WIDTH = 4; constant RESULT_WIDTH = 5; reset value constant RESULT_RST = 5'b0.
- One sub-module: full_adder_cell (inputs a, b, ci; outputs s, co), instantiated four times in a ripple chain.
- The top level contains the bit-vector packing, the chain and the output register.

Test Plan:
- Reset: drive rst_n=0 with A=4'b1111, B=4'b1111, cin=1 for 2 edges -> c4,s4..s1 = 0,0000. Release rst_n -> after the next edge, outputs = 1,1111.
- No-carry: A=1010, B=0101, cin=0 -> one edge later c4=0, s4..s1=1111.
- Carry-out: A=1011, B=0111, cin=0 -> c4=1, s4..s1=0010. Then A=1011, B=1111, cin=0 -> c4=1, s4..s1=1010.
- Full ripple: A=1001, B=0111, cin=0 -> c4=1, s4..s1=0000. Then A=1111, B=0000, cin=1 -> c4=1, s4..s1=0000.
- Latency/pipelining: change operands every cycle -> each output set matches the operands sampled on the previous edge. rst_n=0 asserted for one edge mid-stream -> that cycle's outputs = 0, and the next valid result appears one edge after release.
- Exhaustive: sweep all 512 (A,B,cin) combinations with rst_n=1 -> every registered result equals A+B+cin one cycle later.

Source files
------------

// File: rtl/four_bit_adder_pkg.sv
// rtl/four_bit_adder_pkg.sv - shared widths and reset value for the registered nibble adder
package four_bit_adder_pkg;

  localparam int ADDER_WIDTH  = 4;
  localparam int RESULT_WIDTH = 5;
  localparam logic [RESULT_WIDTH-1:0] RESULT_RST = 5'b0;

endpackage : four_bit_adder_pkg

// File: rtl/four_bit_adder_full_adder_cell.sv
// rtl/four_bit_adder_full_adder_cell.sv - single-bit full adder, one link of the ripple chain
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/four_bit_adder.sv
// rtl/four_bit_adder.sv - registered 4-bit ripple-carry adder, scalar operand bits in, 5-bit sum out
module four_bit_adder
  import four_bit_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a3,
  input  logic b3,
  input  logic a2,
  input  logic b2,
  input  logic a1,
  input  logic b1,
  input  logic a0,
  input  logic b0,
  input  logic cin,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic c4
);

  logic [ADDER_WIDTH-1:0]  a_vec;
  logic [ADDER_WIDTH-1:0]  b_vec;
  logic [ADDER_WIDTH-1:0]  sum_vec;
  logic [ADDER_WIDTH:0]    carry_vec;
  logic [RESULT_WIDTH-1:0] result_d;
  logic [RESULT_WIDTH-1:0] result_q;

  assign a_vec        = {a3, a2, a1, a0};
  assign b_vec        = {b3, b2, b1, b0};
  assign carry_vec[0] = cin;

  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_ripple
    full_adder_cell u_cell (
      .a  (a_vec[i]),
      .b  (b_vec[i]),
      .ci (carry_vec[i]),
      .s  (sum_vec[i]),
      .co (carry_vec[i+1])
    );
  end

  assign result_d = {carry_vec[ADDER_WIDTH], sum_vec};

  // Reset wins over the operands on the same edge; otherwise load every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= RESULT_RST;
    end else begin
      result_q <= result_d;
    end
  end

  assign s1 = result_q[0];
  assign s2 = result_q[1];
  assign s3 = result_q[2];
  assign s4 = result_q[3];
  assign c4 = result_q[4];

endmodule : four_bit_adder

// File: tb/tb_four_bit_adder.sv
// tb/tb_four_bit_adder.sv - directed and sweep checks of the registered nibble adder
module tb_four_bit_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic a3, b3, a2, b2, a1, b1, a0, b0, cin;
  logic s1, s2, s3, s4, c4;

  int checks_run  = 0;
  int checks_fail = 0;

  always #5 clk = ~clk;

  four_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a3    (a3),
    .b3    (b3),
    .a2    (a2),
    .b2    (b2),
    .a1    (a1),
    .b1    (b1),
    .a0    (a0),
    .b0    (b0),
    .cin   (cin),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3),
    .s4    (s4),
    .c4    (c4)
  );

  task automatic check_result(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks_run++;
    if (obs !== exp) begin
      checks_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] a, input logic [3:0] b, input logic c);
    rst_n = rst;
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    cin = c;
  endtask

  // Drive, clock one edge, sample 1 time unit later, compare.
  task automatic step(input string tag, input logic rst, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic [4:0] exp);
    drive(rst, a, b, c);
    @(posedge clk);
    #1;
    check_result(tag, {c4, s4, s3, s2, s1}, exp);
  endtask

  initial begin
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    #1;

    step("reset_edge1", 1'b0, 4'b1111, 4'b1111, 1'b1, 5'b0_0000);
    step("reset_edge2", 1'b0, 4'b1111, 4'b1111, 1'b1, 5'b0_0000);
    step("reset_release", 1'b1, 4'b1111, 4'b1111, 1'b1, 5'b1_1111);

    step("no_carry", 1'b1, 4'b1010, 4'b0101, 1'b0, 5'b0_1111);
    step("carry_out_a", 1'b1, 4'b1011, 4'b0111, 1'b0, 5'b1_0010);
    step("carry_out_b", 1'b1, 4'b1011, 4'b1111, 1'b0, 5'b1_1010);
    step("ripple_a", 1'b1, 4'b1001, 4'b0111, 1'b0, 5'b1_0000);
    step("ripple_cin", 1'b1, 4'b1111, 4'b0000, 1'b1, 5'b1_0000);
    step("zero", 1'b1, 4'b0000, 4'b0000, 1'b0, 5'b0_0000);
    step("cin_only", 1'b1, 4'b0000, 4'b0000, 1'b1, 5'b0_0001);

    // Operands change every cycle; each edge shows the previous cycle's operands.
    step("pipe_0", 1'b1, 4'b0011, 4'b0100, 1'b0, 5'b0_0111);
    step("pipe_1", 1'b1, 4'b1000, 4'b1000, 1'b1, 5'b1_0001);
    step("pipe_2", 1'b1, 4'b0110, 4'b0110, 1'b0, 5'b0_1100);
    step("pipe_mid_reset", 1'b0, 4'b1111, 4'b1111, 1'b0, 5'b0_0000);
    step("pipe_after_reset", 1'b1, 4'b0101, 4'b0010, 1'b1, 5'b0_1000);
    step("pipe_3", 1'b1, 4'b1110, 4'b0001, 1'b1, 5'b1_0000);

    // Output must hold with no edge in between.
    drive(1'b1, 4'b0001, 4'b0001, 1'b0);
    #3;
    check_result("hold_between_edges", {c4, s4, s3, s2, s1}, 5'b1_0000);
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp_sum;
          exp_sum = 5'(a) + 5'(b) + 5'(c);
          step("sweep", 1'b1, 4'(a), 4'(b), 1'(c), exp_sum);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_fail);
    $finish;
  end

endmodule : tb_four_bit_adder
